// File: rtl/out_merge_dwc.sv
// Merges a wide g word stream and a narrow h word stream onto one 256-bit output (optional stats: OUT_MERGE_STAT_EN).
// Latency: first output beat one cycle after input accept; g is serialized over G_RATIO beats, h is one beat.
// Backpressure: an output stall holds the beat; inputs are accepted only when output is empty or its last beat handshakes.
module out_merge_dwc #(
  parameter int G_RATIO = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [256*G_RATIO-1:0]   s_axis_g_tdata,
  input  logic                     s_axis_g_tvalid,
  output logic                     s_axis_g_tready,
  input  logic [255:0]             s_axis_h_tdata,
  input  logic                     s_axis_h_tvalid,
  output logic                     s_axis_h_tready,
  output logic [255:0]             m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser
`ifdef OUT_MERGE_STAT_EN
  ,
  output logic [31:0]              stat_g_cnt,
  output logic [31:0]              stat_h_cnt
`endif
);

  localparam int GW    = 256 * G_RATIO;
  localparam int CNT_W = (G_RATIO > 1) ? $clog2(G_RATIO) : 1;

  typedef enum logic [1:0] {IDLE, G_SER, H_OUT} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    sreg_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             last_grant_h_q;
  logic             load_ok, grant_g, grant_h, g_acc, h_acc, out_hs;

  assign m_axis_tvalid = (state_q != IDLE);
  assign m_axis_tuser  = (state_q == H_OUT);
  assign m_axis_tlast  = (state_q == H_OUT) ||
                         ((state_q == G_SER) && (beat_cnt_q == CNT_W'(G_RATIO - 1)));
  assign m_axis_tdata  = sreg_q[255:0];

  assign out_hs  = m_axis_tvalid && m_axis_tready;
  assign load_ok = !m_axis_tvalid || (out_hs && m_axis_tlast);

  // Round-robin only matters on a tie; a lone requester always wins.
  assign grant_g = s_axis_g_tvalid && (!s_axis_h_tvalid || last_grant_h_q);
  assign grant_h = s_axis_h_tvalid && !grant_g;

  assign s_axis_g_tready = rst_n && load_ok && grant_g;
  assign s_axis_h_tready = rst_n && load_ok && grant_h;
  assign g_acc = s_axis_g_tvalid && s_axis_g_tready;
  assign h_acc = s_axis_h_tvalid && s_axis_h_tready;

  always_comb begin
    state_d = state_q;
    if (g_acc)
      state_d = G_SER;
    else if (h_acc)
      state_d = H_OUT;
    else if (out_hs && m_axis_tlast)
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Beat 0 always sits in the low 256 bits; the register shifts down per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q         <= '0;
      beat_cnt_q     <= '0;
      last_grant_h_q <= 1'b1;
    end else if (g_acc) begin
      sreg_q         <= s_axis_g_tdata;
      beat_cnt_q     <= '0;
      last_grant_h_q <= 1'b0;
    end else if (h_acc) begin
      sreg_q         <= GW'(s_axis_h_tdata);
      beat_cnt_q     <= '0;
      last_grant_h_q <= 1'b1;
    end else if (out_hs && !m_axis_tlast) begin
      sreg_q         <= sreg_q >> 256;
      beat_cnt_q     <= beat_cnt_q + CNT_W'(1);
    end
  end

`ifdef OUT_MERGE_STAT_EN
  logic [31:0] stat_g_q, stat_h_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_g_q <= '0;
      stat_h_q <= '0;
    end else begin
      if (g_acc) stat_g_q <= stat_g_q + 32'd1;
      if (h_acc) stat_h_q <= stat_h_q + 32'd1;
    end
  end

  assign stat_g_cnt = stat_g_q;
  assign stat_h_cnt = stat_h_q;
`endif

endmodule

// File: tb/tb_out_merge_dwc.sv
// Randomized and directed bench for out_merge_dwc against a packet-level queue model.
module tb_out_merge_dwc;

  localparam int R  = 5;
  localparam int GW = 256 * R;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [GW-1:0]   g_dat;
  logic            g_vld, g_rdy;
  logic [255:0]    h_dat;
  logic            h_vld, h_rdy;
  logic [255:0]    m_dat;
  logic            m_vld, m_rdy, m_last, m_user;
`ifdef OUT_MERGE_STAT_EN
  logic [31:0]     stat_g, stat_h;
  logic [31:0]     exp_sg, exp_sh;
`endif

  always #5 clk = ~clk;

  out_merge_dwc #(.G_RATIO(R)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_g_tdata  (g_dat),
    .s_axis_g_tvalid (g_vld),
    .s_axis_g_tready (g_rdy),
    .s_axis_h_tdata  (h_dat),
    .s_axis_h_tvalid (h_vld),
    .s_axis_h_tready (h_rdy),
    .m_axis_tdata    (m_dat),
    .m_axis_tvalid   (m_vld),
    .m_axis_tready   (m_rdy),
    .m_axis_tlast    (m_last),
    .m_axis_tuser    (m_user)
`ifdef OUT_MERGE_STAT_EN
    ,
    .stat_g_cnt      (stat_g),
    .stat_h_cnt      (stat_h)
`endif
  );

  typedef struct {
    logic [255:0] d;
    logic         l;
    logic         u;
  } beat_t;

  beat_t        expq[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_out   = 0;
  logic         last_h;
  logic         stall_prev;
  beat_t        held;
  logic         last_ga, last_ha;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [GW-1:0] rand_g();
    logic [GW-1:0] w;
    for (int i = 0; i < GW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [255:0] rand_h();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Inputs are driven just after a negedge; this samples the settled handshake
  // signals that take effect at the next posedge, then advances one cycle.
  task automatic tick();
    logic  ga, ha, oh;
    beat_t b;
    #1;
    ga = g_vld && g_rdy;
    ha = h_vld && h_rdy;
    oh = m_vld && m_rdy;
    chk("rdy_excl", 256'(g_rdy && h_rdy), 256'(0));
    chk("tvalid", 256'(m_vld), 256'(expq.size() != 0));
    if (stall_prev) begin
      chk("hold_dat", m_dat, held.d);
      chk("hold_last", 256'(m_last), 256'(held.l));
      chk("hold_user", 256'(m_user), 256'(held.u));
    end
    if (!m_vld && (g_vld || h_vld)) chk("idle_accept", 256'(ga || ha), 256'(1));
    if (oh && m_last && (g_vld || h_vld)) chk("no_bubble", 256'(ga || ha), 256'(1));
    if (m_vld && !(oh && m_last)) chk("busy_noacc", 256'(ga || ha), 256'(0));
    if (g_vld && h_vld && (ga || ha)) chk("rr_grant", 256'(ga), 256'(last_h));
    if (oh) begin
      n_out++;
      if (expq.size() == 0) begin
        chk("unexp_beat", 256'(1), 256'(0));
      end else begin
        b = expq.pop_front();
        chk("beat_dat", m_dat, b.d);
        chk("beat_last", 256'(m_last), 256'(b.l));
        chk("beat_user", 256'(m_user), 256'(b.u));
      end
    end
    if (ga) begin
      for (int k = 0; k < R; k++) begin
        b.d = g_dat[k*256 +: 256];
        b.l = (k == R - 1);
        b.u = 1'b0;
        expq.push_back(b);
      end
      last_h = 1'b0;
`ifdef OUT_MERGE_STAT_EN
      exp_sg = exp_sg + 32'd1;
`endif
    end
    if (ha) begin
      b.d = h_dat;
      b.l = 1'b1;
      b.u = 1'b1;
      expq.push_back(b);
      last_h = 1'b1;
`ifdef OUT_MERGE_STAT_EN
      exp_sh = exp_sh + 32'd1;
`endif
    end
    stall_prev = m_vld && !m_rdy;
    held.d = m_dat;
    held.l = m_last;
    held.u = m_user;
    last_ga = ga;
    last_ha = ha;
    @(negedge clk);
  endtask

  task automatic reset_and_check(input string tag);
    rst_n = 1'b0;
    g_vld = 1'b1;
    h_vld = 1'b1;
    #1;
    chk({tag, "_tvalid"}, 256'(m_vld), 256'(0));
    chk({tag, "_tlast"}, 256'(m_last), 256'(0));
    chk({tag, "_tuser"}, 256'(m_user), 256'(0));
    chk({tag, "_tdata"}, m_dat, 256'(0));
    chk({tag, "_grdy"}, 256'(g_rdy), 256'(0));
    chk({tag, "_hrdy"}, 256'(h_rdy), 256'(0));
    expq.delete();
    last_h     = 1'b1;
    stall_prev = 1'b0;
`ifdef OUT_MERGE_STAT_EN
    exp_sg = '0;
    exp_sh = '0;
`endif
    g_vld = 1'b0;
    h_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    g_vld = 1'b0;
    h_vld = 1'b0;
    m_rdy = 1'b1;
    repeat (R + 2) tick();
    chk("drained", 256'(expq.size()), 256'(0));
  endtask

  initial begin
    int pat[4] = '{1, 0, 0, 1};
    int base;
    rst_n = 1'b0;
    g_vld = 1'b0;
    h_vld = 1'b0;
    m_rdy = 1'b0;
    g_dat = '0;
    h_dat = '0;
    @(negedge clk);
    reset_and_check("rst");

    // Single g word, beat k carries value k.
    for (int k = 0; k < R; k++) g_dat[k*256 +: 256] = 256'(k);
    g_vld = 1'b1;
    m_rdy = 1'b1;
    tick();
    chk("g_acc_single", 256'(last_ga), 256'(1));
    g_vld = 1'b0;
    base = n_out;
    repeat (R) tick();
    chk("single_beats", 256'(n_out - base), 256'(R));
    drain();

    // Both sources continuously valid: g, h, g, h with no idle cycles.
    g_vld = 1'b1; g_dat = rand_g();
    h_vld = 1'b1; h_dat = rand_h();
    m_rdy = 1'b1;
    tick();
    base = n_out;
    repeat (2 * (R + 1)) begin
      if (last_ga) g_dat = rand_g();
      if (last_ha) h_dat = rand_h();
      tick();
    end
    chk("no_idle_mix", 256'(n_out - base), 256'(2 * (R + 1)));
    drain();

    // Stalled g word with a queued g behind it.
    g_vld = 1'b1; g_dat = rand_g();
    for (int c = 0; c < 4 * R; c++) begin
      m_rdy = pat[c % 4][0];
      if (last_ga && c > 0) g_dat = rand_g();
      tick();
    end
    drain();

    // Back-to-back h words.
    h_vld = 1'b1;
    m_rdy = 1'b1;
    h_dat = 256'hA; tick(); chk("h_acc_a", 256'(last_ha), 256'(1));
    h_dat = 256'hB; tick(); chk("h_acc_b", 256'(last_ha), 256'(1));
    h_dat = 256'hC; tick(); chk("h_acc_c", 256'(last_ha), 256'(1));
    h_vld = 1'b0;
    drain();

    // Reset in the middle of a g packet.
    g_vld = 1'b1; g_dat = rand_g();
    tick();
    g_vld = 1'b0;
    repeat (3) tick();
    reset_and_check("mid_rst");
    h_vld = 1'b1; h_dat = rand_h();
    tick();
    h_vld = 1'b0;
    drain();

    // Randomized traffic and backpressure.
    for (int c = 0; c < 2000; c++) begin
      if (!g_vld || last_ga) begin
        g_vld = ($urandom_range(0, 2) == 0);
        g_dat = rand_g();
      end
      if (!h_vld || last_ha) begin
        h_vld = ($urandom_range(0, 1) == 0);
        h_dat = rand_h();
      end
      m_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

`ifdef OUT_MERGE_STAT_EN
    chk("stat_g", 256'(stat_g), 256'(exp_sg));
    chk("stat_h", 256'(stat_h), 256'(exp_sh));
    dut.stat_g_q = 32'hFFFF_FFFF;
    exp_sg = 32'hFFFF_FFFF;
    g_vld = 1'b1; g_dat = rand_g();
    tick();
    g_vld = 1'b0;
    drain();
    chk("stat_g_wrap", 256'(stat_g), 256'(exp_sg));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/out_merge_dwc.md
OUT_MERGE_DWC -- requirements
Module: out_merge_dwc

Interface
REQ-001 Parameter G_RATIO, default 5: number of 256-bit output beats per g word; g input width is 256*G_RATIO.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_axis_g_tdata  input  1280  g word from upstream output switch (g register slice).
REQ-005 s_axis_g_tvalid / s_axis_g_tready  input / output  1 each  g handshake.
REQ-006 s_axis_h_tdata  input  256  h word from upstream output switch (h register slice).
REQ-007 s_axis_h_tvalid / s_axis_h_tready  input / output  1 each  h handshake.
REQ-008 m_axis_tdata  output  256  merged, serialized output beat.
REQ-009 m_axis_tvalid / m_axis_tready  output / input  1 each  output handshake.
REQ-010 m_axis_tlast  output  1  high on final beat of a packet (beat G_RATIO-1 of g; every h beat).
REQ-011 m_axis_tuser  output  1  source tag: 0 = g, 1 = h.

Function
REQ-012 States: IDLE (output empty), G_SER (g beats outstanding), H_OUT (h beat outstanding).
REQ-013 load_ok = !m_axis_tvalid OR (m_axis_tvalid AND m_axis_tready AND m_axis_tlast).
REQ-014 Grant: only g valid -> g; only h valid -> h; both valid -> source opposite to last_grant (round-robin); last_grant resets to h, so g wins first tie.
REQ-015 s_axis_g_tready = load_ok AND grant==g; s_axis_h_tready = load_ok AND grant==h; never both high in one cycle.
REQ-016 g accept: capture 1280 bits into shift register, beat_cnt=0, state G_SER, m_axis_tvalid=1 next cycle (latency 1).
REQ-017 g beat order: bits [255:0] first, then [511:256], ..., [1279:1024] last.
REQ-018 In G_SER each output handshake advances beat_cnt by 1; tlast=1 when beat_cnt==G_RATIO-1; tuser=0.
REQ-019 h accept: capture 256 bits, state H_OUT, tvalid=1 next cycle, tlast=1, tuser=1.
REQ-020 On final-beat handshake: if a new word is granted the same cycle, load it with no bubble; else state IDLE, tvalid=0.
REQ-021 Sustained throughput: one output beat per cycle with tready held high (g: 5 cycles/word, h: 1 cycle/word).
REQ-022 While tvalid=1 and tready=0, tdata/tlast/tuser and state hold stable.
REQ-023 last_grant updates only on an accepted input handshake.

Reset
REQ-024 While rst_n=0: state IDLE, beat_cnt=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, both s_*_tready=0, last_grant=h.
REQ-025 Reset mid-packet discards remaining beats; no partial packet resumes after rst_n deasserts.
REQ-026 First cycle after deassert: tready follows REQ-015 with load_ok=1.

Configuration
REQ-027 Macro OUT_MERGE_STAT_EN defined: adds outputs stat_g_cnt[31:0] and stat_h_cnt[31:0], counting accepted g/h input words, reset to 0, wrapping 0xFFFFFFFF -> 0.
REQ-028 Macro undefined: stat ports and counters absent; all other behaviour identical.

Verification
REQ-029 Single g word 0x...0004_..._0000 (beat k = 256'hk) with tready=1 -> 5 beats in consecutive cycles, data 0..4, tlast only on 5th, tuser=0, first beat 1 cycle after accept.
REQ-030 g and h valid together continuously, tready=1 -> output sequence g(5 beats), h(1), g(5), h(1); no idle cycle between packets.
REQ-031 g accepted, m_axis_tready toggled 1,0,0,1,... -> each beat held stable while stalled; exactly 5 beats, order preserved; s_axis_g_tready=0 until final beat handshakes.
REQ-032 Back-to-back h words 0xA, 0xB, 0xC, no g, tready=1 -> outputs 0xA, 0xB, 0xC on consecutive cycles, tlast=1, tuser=1 each.
REQ-033 rst_n pulled low after beat 2 of a g word -> tvalid=0 asynchronously; after release, next input word starts at beat 0.
REQ-034 With OUT_MERGE_STAT_EN: 3 g + 2 h words accepted -> stat_g_cnt=3, stat_h_cnt=2; counter preloaded to 0xFFFFFFFF plus one accept -> 0.
